shift_feeder: RTL
=================

Name: shift_feeder

Overview:
- Buffered command stage directly upstream of the barrel shifter.
- Accepts shift commands {operand, shift/rotate select, shift amount, direction} through a valid/ready push interface and holds them in a DEPTH-entry circular FIFO.
- Presents the oldest command on registered outputs that wire straight to the barrel shifter's input, sr, shift and direction ports, so the shifter sees stable, glitch-free operands.
- Downstream consumer paces issue with a ready signal.

Parameters:
- SIZE, 4, operand width in bits; must match the barrel shifter's SIZE.
- DEPTH, 4, FIFO storage entries; power of two, >= 2.

Ports:
- shift_feeder_port_clk  input  1  rising-edge clock
- shift_feeder_port_reset_n  input  1  synchronous active-low reset
- shift_feeder_port_in_valid  input  1  push request
- shift_feeder_port_in_ready  output  1  space available (combinational from count)
- shift_feeder_port_in_data  input  SIZE  operand
- shift_feeder_port_in_sr  input  1  0 = shift, 1 = rotate; passed through unchanged
- shift_feeder_port_in_shift  input  $clog2(SIZE)  shift amount
- shift_feeder_port_in_direction  input  1  direction bit; passed through unchanged
- shift_feeder_port_out_valid  output  1  output register holds a command
- shift_feeder_port_out_ready  input  1  consumer takes command this cycle
- shift_feeder_port_out_data  output  SIZE  to barrelShifter_port_input
- shift_feeder_port_out_sr  output  1  to barrelShifter_port_sr
- shift_feeder_port_out_shift  output  $clog2(SIZE)  to barrelShifter_port_shift
- shift_feeder_port_out_direction  output  1  to barrelShifter_port_direction
- shift_feeder_port_count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH, output register excluded
- shift_feeder_port_overflow_cnt  output  8  rejected-push counter (see Optional Feature)

Behaviour:
- Reset, sampled on the clock edge while reset_n = 0:
  - read/write pointers and count go to 0.
  - out_valid and all out_* fields go to 0.
  - overflow_cnt goes to 0.
  - Any command in flight, stored or in the output register, is discarded; no partial state survives.
- Command word:
  - {data, sr, shift, direction}, SIZE + $clog2(SIZE) + 2 bits, stored and forwarded bit-exact.
  - No range checking. Shift width is $clog2(SIZE), so the amount is always < SIZE.
- Push:
  - Accepted on a clock edge when in_valid & in_ready. The word is written at the write pointer and the pointer increments modulo DEPTH.
  - in_ready = (count < DEPTH). It does not look ahead at a same-cycle pop, so a push while full is rejected even if a pop occurs that cycle.
- Output register. Two-state control, EMPTY (out_valid = 0) and HOLD (out_valid = 1):
  - Load condition: (!out_valid | out_ready) & (count > 0). The head entry moves into the out_* registers, the read pointer increments modulo DEPTH, and out_valid goes to 1.
  - HOLD -> EMPTY when out_ready = 1 and count = 0.
  - In HOLD with out_ready = 0, all out_* fields hold their values.
  - out_ready while EMPTY is ignored.
- Count update:
  - +1 on an accepted push only.
  - -1 on a load only.
  - Unchanged when both occur in the same cycle.
  - Never exceeds DEPTH and never goes below 0.
- Latency: a push accepted at edge N into an empty feeder gives out_valid = 1 after edge N+1. There is no push-to-output bypass.
- Throughput: one command per cycle sustained when in_valid and out_ready are both held high.
- Ordering: strict FIFO; pointer wrap-around is transparent.
- Total buffered commands = DEPTH + 1 (storage plus output register).

Optional Feature:
- Macro: SHIFT_FEEDER_OVERFLOW_EN.
- Defined: overflow_cnt increments by 1 on every cycle with in_valid = 1 and in_ready = 0. It saturates at 255 and is cleared only by reset.
- Not defined: the counter logic is omitted and overflow_cnt is tied to 0.
- Push, pop and count behaviour are identical with or without the macro.

Test Plan:
- Reset, then push {data=4'b1001, sr=1, shift=2'd1, dir=0} with out_ready=0 -> after 2 edges out_valid=1, out_data=1001, out_sr=1, out_shift=1, out_dir=0, count=0; outputs stay stable for 5 held cycles.
- Push 5 commands with data 1..5, out_ready=0 -> in_ready=0 after the 5th (count=4, output holds data=1). A 6th push is rejected; with OVERFLOW_EN, overflow_cnt=1.
- From the full state, raise out_ready for 5 cycles -> out_data sequence 1,2,3,4,5, then out_valid=0 and count=0.
- in_valid=1 and out_ready=1 for 20 cycles, data incrementing 0..15 and wrapping -> one output per cycle, in order, count never above 1, pointers wrap cleanly.
- With 3 commands buffered and out_valid=1, assert reset_n=0 for 1 cycle -> out_valid=0, out_* =0, count=0, in_ready=1. Commands pushed afterwards emerge first with no stale data.
- Sweep all 2 dir × 4 shift × 2 sr × 16 data combinations through the feeder into the barrel shifter -> shifter output matches a reference model for every command, in push order.

Source files
------------

// File: rtl/shift_feeder.sv
// -----------------------------------------------------------------------------
// shift_feeder
//   Buffered command stage in front of the barrel shifter. Shift commands
//   {data, sr, shift, direction} are pushed through a valid/ready interface
//   into a DEPTH-entry circular FIFO. The oldest command is moved into a
//   registered output stage that drives the shifter directly, so the
//   shifter's operands only change on a clock edge.
//
//   Optional feature macro: SHIFT_FEEDER_OVERFLOW_EN
//     defined   -> overflow_cnt counts cycles with a push offered while full
//                  (saturates at 255, cleared only by reset)
//     undefined -> overflow_cnt is tied to 0
//
// Ports
//   shift_feeder_port_clk            rising-edge clock
//   shift_feeder_port_reset_n        synchronous active-low reset
//   shift_feeder_port_in_valid       push request
//   shift_feeder_port_in_ready       space available (count < DEPTH)
//   shift_feeder_port_in_data        operand, SIZE bits
//   shift_feeder_port_in_sr          0 = shift, 1 = rotate
//   shift_feeder_port_in_shift       shift amount, $clog2(SIZE) bits
//   shift_feeder_port_in_direction   direction bit
//   shift_feeder_port_out_valid      output register holds a command
//   shift_feeder_port_out_ready      consumer takes the command this cycle
//   shift_feeder_port_out_data       to barrel shifter input
//   shift_feeder_port_out_sr         to barrel shifter sr
//   shift_feeder_port_out_shift      to barrel shifter shift
//   shift_feeder_port_out_direction  to barrel shifter direction
//   shift_feeder_port_count          FIFO occupancy 0..DEPTH (output reg excluded)
//   shift_feeder_port_overflow_cnt   rejected-push counter
// -----------------------------------------------------------------------------
module shift_feeder #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       shift_feeder_port_clk,
  input  logic                       shift_feeder_port_reset_n,
  input  logic                       shift_feeder_port_in_valid,
  output logic                       shift_feeder_port_in_ready,
  input  logic [SIZE-1:0]            shift_feeder_port_in_data,
  input  logic                       shift_feeder_port_in_sr,
  input  logic [$clog2(SIZE)-1:0]    shift_feeder_port_in_shift,
  input  logic                       shift_feeder_port_in_direction,
  output logic                       shift_feeder_port_out_valid,
  input  logic                       shift_feeder_port_out_ready,
  output logic [SIZE-1:0]            shift_feeder_port_out_data,
  output logic                       shift_feeder_port_out_sr,
  output logic [$clog2(SIZE)-1:0]    shift_feeder_port_out_shift,
  output logic                       shift_feeder_port_out_direction,
  output logic [$clog2(DEPTH):0]     shift_feeder_port_count,
  output logic [7:0]                 shift_feeder_port_overflow_cnt
);

  localparam int SHW    = $clog2(SIZE);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = SIZE + SHW + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   out_word_q, out_word_d;

  // Command storage; contents need no reset because pointers and count do.
  logic [WORD_W-1:0]   mem [DEPTH];

  logic                push;
  logic                load;
  logic [WORD_W-1:0]   in_word;
  logic [WORD_W-1:0]   head_word;

  assign in_word   = {shift_feeder_port_in_data, shift_feeder_port_in_sr,
                      shift_feeder_port_in_shift, shift_feeder_port_in_direction};
  assign head_word = mem[rd_ptr_q];

  // Readiness is based on current occupancy only; a same-cycle pop does not
  // free a slot for a push.
  assign shift_feeder_port_in_ready = (count_q < DEPTH_C);
  assign push = shift_feeder_port_in_valid & shift_feeder_port_in_ready;
  assign load = ((state_q == ST_EMPTY) | shift_feeder_port_out_ready) & (count_q != '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_word_d = out_word_q;

    case (state_q)
      ST_EMPTY: if (load) state_d = ST_HOLD;
      ST_HOLD:  if (!load && shift_feeder_port_out_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    // DEPTH is a power of two, so the pointer increment wraps naturally.
    if (load) begin
      out_word_d = head_word;
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({push, load})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge shift_feeder_port_clk) begin
    if (!shift_feeder_port_reset_n) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_word_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_word_q <= out_word_d;
    end
  end

  always_ff @(posedge shift_feeder_port_clk) begin
    if (push) mem[wr_ptr_q] <= in_word;
  end

  assign shift_feeder_port_out_valid     = (state_q == ST_HOLD);
  assign shift_feeder_port_out_data      = out_word_q[WORD_W-1 -: SIZE];
  assign shift_feeder_port_out_sr        = out_word_q[SHW+1];
  assign shift_feeder_port_out_shift     = out_word_q[SHW:1];
  assign shift_feeder_port_out_direction = out_word_q[0];
  assign shift_feeder_port_count         = count_q;

`ifdef SHIFT_FEEDER_OVERFLOW_EN
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (shift_feeder_port_in_valid && !shift_feeder_port_in_ready && (ovf_q != 8'hFF))
      ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge shift_feeder_port_clk) begin
    if (!shift_feeder_port_reset_n) ovf_q <= '0;
    else                            ovf_q <= ovf_d;
  end

  assign shift_feeder_port_overflow_cnt = ovf_q;
`else
  assign shift_feeder_port_overflow_cnt = '0;
`endif

endmodule
